// File: rtl/operand_fetch_pkg.sv
// Shared widths and encodings for the operand-fetch stage and its register file.
package operand_fetch_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_COUNT = 8;
  localparam int ADDR_W    = $clog2(REG_COUNT);
  localparam int OP_W      = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

endpackage

// File: rtl/reg_file.sv
// General register file with two combinational read ports and same-cycle write-back bypass.
module reg_file #(
  parameter int DATA_W    = operand_fetch_pkg::DATA_W,
  parameter int REG_COUNT = operand_fetch_pkg::REG_COUNT,
  localparam int ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);
  import operand_fetch_pkg::*;

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic              wr_ok;

  // r0 is hard-wired to zero, so it is never a write or bypass target
  assign wr_ok = wb_en_i && (wb_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign rd1_o = (rs1_i == '0)                     ? '0        :
                 (wr_ok && (wb_addr_i == rs1_i))   ? wb_data_i :
                                                     regs_q[rs1_i];
  assign rd2_o = (rs2_i == '0)                     ? '0        :
                 (wr_ok && (wb_addr_i == rs2_i))   ? wb_data_i :
                                                     regs_q[rs2_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads sources through reg_file and holds one operand bundle for the ALU.
module operand_fetch #(
  parameter int DATA_W    = operand_fetch_pkg::DATA_W,
  parameter int REG_COUNT = operand_fetch_pkg::REG_COUNT,
  parameter int OP_W      = operand_fetch_pkg::OP_W,
  localparam int ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   in_opcode_i,
  input  logic [ADDR_W-1:0] in_rs1_i,
  input  logic [ADDR_W-1:0] in_rs2_i,
  input  logic [ADDR_W-1:0] in_rd_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OP_W-1:0]   out_opcode_o,
  output logic [ADDR_W-1:0] out_rd_o,
  output logic [DATA_W-1:0] out_a_o,
  output logic [DATA_W-1:0] out_b_o
);
  import operand_fetch_pkg::*;

  stage_e            state_q, state_d;
  logic              accept, load;
  logic [DATA_W-1:0] opa, opb;
  logic [OP_W-1:0]   opcode_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] a_q, b_q;

  reg_file #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wb_en_i   (wb_en_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .rs1_i     (in_rs1_i),
    .rs2_i     (in_rs2_i),
    .rd1_o     (opa),
    .rd2_o     (opb)
  );

  // Ready is purely a function of the output slot, never of in_valid
  assign in_ready_o = !rst_i && ((state_q == ST_EMPTY) || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (accept) begin
      state_d = ST_FULL;
      load    = 1'b1;
    end else if ((state_q == ST_FULL) && out_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_EMPTY;
      opcode_q <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        opcode_q <= in_opcode_i;
        rd_q     <= in_rd_i;
        a_q      <= opa;
        b_q      <= opb;
      end
    end
  end

  assign out_valid_o  = (state_q == ST_FULL);
  assign out_opcode_o = opcode_q;
  assign out_rd_o     = rd_q;
  assign out_a_o      = a_q;
  assign out_b_o      = b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table plus hand sequences, outputs checked through a scoreboard.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [2:0] in_opcode, in_rs1, in_rs2, in_rd, wb_addr, out_opcode, out_rd;
  logic [7:0] wb_data, out_a, out_b;
  logic [21:0] obus;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  int base;
  logic [21:0] exp_q[$];
  logic [21:0] mon_e;

  typedef struct {
    bit         v;
    bit         we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] op, rs1, rs2, rd;
    logic [7:0] ea, eb;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_opcode_i(in_opcode), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_opcode_o(out_opcode), .out_rd_o(out_rd), .out_a_o(out_a), .out_b_o(out_b)
  );

  assign obus = {out_opcode, out_rd, out_a, out_b};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Every transfer to the ALU must match the oldest expected bundle
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer actual=%h expected=none", obus);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer", {10'd0, obus}, {10'd0, mon_e});
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    //          v  we  wa    wd     op       rs1   rs2   rd    ea     eb
    tbl[0] = '{1'b0, 1'b1, 3'd3, 8'hA5, OP_AND,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 3'd5, 8'h3C, OP_AND,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 3'd0, 8'h00, OP_AND,  3'd3, 3'd5, 3'd1, 8'hA5, 8'h3C};
    tbl[3] = '{1'b1, 1'b1, 3'd2, 8'h7F, OP_ADD,  3'd2, 3'd3, 3'd4, 8'h7F, 8'hA5};
    tbl[4] = '{1'b1, 1'b1, 3'd0, 8'hFF, OP_OR,   3'd0, 3'd0, 3'd2, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 3'd0, 8'h00, OP_XOR,  3'd0, 3'd2, 3'd3, 8'h00, 8'h7F};
    tbl[6] = '{1'b1, 1'b1, 3'd5, 8'h11, OP_SUB,  3'd5, 3'd5, 3'd5, 8'h11, 8'h11};
    tbl[7] = '{1'b1, 1'b0, 3'd0, 8'h00, OP_SLL,  3'd5, 3'd3, 3'd6, 8'h11, 8'hA5};
    tbl[8] = '{1'b1, 1'b1, 3'd7, 8'hFF, OP_SRL,  3'd7, 3'd6, 3'd7, 8'hFF, 8'h00};
    tbl[9] = '{1'b1, 1'b0, 3'd0, 8'h00, OP_PASS, 3'd7, 3'd1, 3'd1, 8'hFF, 8'h00};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", {out_valid, obus}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = tbl[i].v;  wb_en = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
      in_opcode = tbl[i].op; in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2; in_rd = tbl[i].rd;
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1);
      if (tbl[i].v) exp_q.push_back({tbl[i].op, tbl[i].rd, tbl[i].ea, tbl[i].eb});
      if (i > 0 && tbl[i-1].v) chk("stream_valid", out_valid, 1);
    end
    @(posedge clk); #1 in_valid = 1'b0; wb_en = 1'b0;
    drain();

    // Stall with write-back to a captured source, and a refused instruction pending
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = OP_OR; in_rs1 = 3'd3; in_rs2 = 3'd5; in_rd = 3'd6;
    @(negedge clk);
    exp_q.push_back({OP_OR, 3'd6, 8'hA5, 8'h11});
    @(posedge clk); #1;
    out_ready = 1'b0; in_opcode = OP_PASS; in_rs1 = 3'd1; in_rs2 = 3'd2; in_rd = 3'd7;
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h99;
    base = xfers;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", {10'd0, obus}, {10'd0, OP_OR, 3'd6, 8'hA5, 8'h11});
      @(posedge clk); #1 wb_en = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_drained", out_valid, 0);
    chk("stall_one_xfer", xfers - base, 1);

    // Reset while FULL discards the bundle and clears r3
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = OP_ADD; in_rs1 = 3'd3; in_rs2 = 3'd0; in_rd = 3'd2; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("full_before_rst", {out_valid, out_a}, {1'b1, 8'h99});
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h55;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_flush", {out_valid, out_a}, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = OP_SUB; in_rs1 = 3'd3; in_rs2 = 3'd4; in_rd = 3'd5;
    @(negedge clk);
    exp_q.push_back({OP_SUB, 3'd5, 8'h00, 8'h00});
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
